// File: rtl/mem_pkg.sv
// Shared types and constants for the MIO memory responder.
package mem_pkg;
    localparam int MEM_WORD_W = 16;
    localparam int CPU_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;
endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory MIO handshake bundle.
interface mem_responder_if;
    import mem_pkg::*;

    logic                  MIO_EN;
    logic                  WE;
    logic [CPU_ADDR_W-1:0] ADDR;
    logic [MEM_WORD_W-1:0] Data_from_CPU;
    logic [MEM_WORD_W-1:0] Data_to_CPU;
    logic                  Ready;
    logic                  Err;

    modport master (
        output MIO_EN, WE, ADDR, Data_from_CPU,
        input  Data_to_CPU, Ready, Err
    );

    modport slave (
        input  MIO_EN, WE, ADDR, Data_from_CPU,
        output Data_to_CPU, Ready, Err
    );
endinterface

// File: rtl/mem_array_16.sv
// Single-port synchronous 16-bit RAM, write-first, no reset.
// Isolated so a vendor block RAM can drop in with the same ports.
module mem_array_16
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                  Clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [MEM_WORD_W-1:0] din,
    output logic [MEM_WORD_W-1:0] dout
);
    logic [MEM_WORD_W-1:0] mem [2**ADDR_BITS];

    // Write-first port: a write also shows the new word on dout.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= din;
            dout      <= din;
        end else begin
            dout <= mem[addr];
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Memory-side MIO responder: captures a CPU request, inserts WAIT_CYCLES
// wait states, services it from mem_array_16 and holds Ready until the
// CPU drops MIO_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    mem_responder_if.slave  mio
);
    mem_state_e            state;
    logic [3:0]            cnt;
    logic                  req_we;
    logic [CPU_ADDR_W-1:0] req_addr;
    logic [MEM_WORD_W-1:0] req_data;
    logic [MEM_WORD_W-1:0] data_q;
    logic [MEM_WORD_W-1:0] ram_dout;
    logic [MEM_WORD_W-1:0] rd_data;
    logic                  rd_live;
    logic                  err_q;
    logic                  req_oor;
    logic                  access;
    logic                  ram_we;

    // The RAM address is always the latched request, so ram_dout already
    // holds array[req_addr] by the time the access edge arrives.
    assign req_oor = |req_addr[CPU_ADDR_W-1:ADDR_BITS];
    assign access  = (state == WAIT) && (cnt == 4'd0) && mio.MIO_EN;
    // Gating with Reset keeps a write from landing on the reset edge.
    assign ram_we  = access && req_we && !req_oor && Reset;

    mem_array_16 #(.ADDR_BITS(ADDR_BITS)) u_array (
        .Clk  (Clk),
        .we   (ram_we),
        .addr (req_addr[ADDR_BITS-1:0]),
        .din  (req_data),
        .dout (ram_dout)
    );

    // After an in-range read the RAM output register is the read data and
    // stays stable until the next capture; otherwise the held copy is shown.
    assign rd_data         = rd_live ? ram_dout : data_q;
    assign mio.Data_to_CPU = rd_data;
    assign mio.Ready       = (state == DONE);
    assign mio.Err         = (state == DONE) && err_q;

    // Request FSM: capture in IDLE, count wait states, access, then hold DONE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_we   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            data_q   <= '0;
            rd_live  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mio.MIO_EN) begin
                        req_we   <= mio.WE;
                        req_addr <= mio.ADDR;
                        req_data <= mio.Data_from_CPU;
                        cnt      <= 4'(WAIT_CYCLES);
                        // Freeze the visible read data before the RAM
                        // address moves to the new request.
                        data_q   <= rd_data;
                        rd_live  <= 1'b0;
                        err_q    <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mio.MIO_EN) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        err_q <= req_oor;
                        state <= DONE;
                        if (!req_we) begin
                            if (req_oor) data_q  <= '0;
                            else         rd_live <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (!mio.MIO_EN) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
